// File: rtl/i2s_pkg.sv
// Shared encodings and types for the I2S receive path: serial standard
// codes, word-size codes, capture FSM states and the stored L/R frame.
package i2s_pkg;

  localparam logic [1:0] I2S_PHILIPS = 2'b00;
  localparam logic [1:0] I2S_LJ      = 2'b01;

  localparam logic [1:0] WS_16 = 2'b00;
  localparam logic [1:0] WS_32 = 2'b01;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [31:0] L;
    logic [31:0] R;
  } frame_t;

endpackage

// File: rtl/i2s_rx_fifo_if.sv
// Bundle of configuration, serial pins and FIFO read side of the I2S
// receiver. slave = the receiver, master = the driver/consumer.
interface i2s_rx_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             en;
  logic             stereo;
  logic [1:0]       standard;
  logic [1:0]       word_size;
  logic             sck;
  logic             ws;
  logic             sd;
  logic             ren;
  logic             clr_err;
  logic [31:0]      doutL;
  logic [31:0]      doutR;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   level;
  logic             overrun;
  logic             frame_err;

  modport slave (
    input  en, stereo, standard, word_size, sck, ws, sd, ren, clr_err,
    output doutL, doutR, full, empty, level, overrun, frame_err
  );

  modport master (
    output en, stereo, standard, word_size, sck, ws, sd, ren, clr_err,
    input  doutL, doutR, full, empty, level, overrun, frame_err
  );

endinterface

// File: rtl/i2s_rx_sync.sv
// Brings the asynchronous sck/ws/sd pins into the wclk domain and produces
// a one-cycle sample strobe three wclk cycles after each sck rise, with
// ws/sd registered alongside it so all three line up.
module i2s_rx_sync (
  input  logic wclk,
  input  logic rst,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic ws_s_o,
  output logic sd_s_o,
  output logic sample_en_o
);

  logic [2:0] sck_q;
  logic [1:0] ws_q;
  logic [1:0] sd_q;
  logic       ws_s_q;
  logic       sd_s_q;
  logic       sample_en_q;

  // Two-flop synchronizers; sck keeps one extra history flop for edge detect
  always_ff @(posedge wclk) begin
    if (rst) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ws_q  <= {ws_q[0], ws_i};
      sd_q  <= {sd_q[0], sd_i};
    end
  end

  // Registered rise pulse with ws/sd captured on the same edge
  always_ff @(posedge wclk) begin
    if (rst) begin
      sample_en_q <= 1'b0;
      ws_s_q      <= 1'b0;
      sd_s_q      <= 1'b0;
    end else begin
      sample_en_q <= sck_q[1] & ~sck_q[2];
      ws_s_q      <= ws_q[1];
      sd_s_q      <= sd_q[1];
    end
  end

  assign ws_s_o      = ws_s_q;
  assign sd_s_o      = sd_s_q;
  assign sample_en_o = sample_en_q;

endmodule

// File: rtl/i2s_rx_fifo.sv
// I2S receiver: oversampled serial capture (Philips or left-justified,
// 16/32-bit, stereo or mono), L/R frame assembly and a first-word
// fall-through frame FIFO for the parallel consumer.
// Build option: define RX_SIGN_EXT_EN to sign-extend 16-bit words into
// [31:16]; otherwise the upper half of a 16-bit word is zero.
module i2s_rx_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          wclk,
  input  logic          rst,
  i2s_rx_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  // Place a raw 16-bit word into a 32-bit slot; 32-bit words pass through.
  function automatic logic [31:0] fit_word(input logic [31:0] raw,
                                           input logic half);
    logic [31:0] w;
    w = raw;
    if (half) begin
`ifdef RX_SIGN_EXT_EN
      w = {{16{raw[15]}}, raw[15:0]};
`else
      w = {16'h0000, raw[15:0]};
`endif
    end
    return w;
  endfunction

  logic ws_s;
  logic sd_s;
  logic sample_en;

  i2s_rx_sync u_sync (
    .wclk        (wclk),
    .rst         (rst),
    .sck_i       (bus.sck),
    .ws_i        (bus.ws),
    .sd_i        (bus.sd),
    .ws_s_o      (ws_s),
    .sd_s_o      (sd_s),
    .sample_en_o (sample_en)
  );

  rx_state_t   state_q, state_d;
  logic [30:0] shreg_q, shreg_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic        chan_q, chan_d;
  logic [31:0] stage_q, stage_d;
  logic        ws_prev_q;

  logic        is16;
  logic        lj;
  logic        ws_edge;
  logic        last_bit;
  logic [31:0] raw_word;
  logic [31:0] word;
  logic        start;
  logic        word_done;
  logic        push;
  frame_t      push_frame;
  logic        ferr_set;

  assign is16     = (bus.word_size == WS_16);
  assign lj       = (bus.standard != I2S_PHILIPS);
  assign ws_edge  = (ws_s != ws_prev_q);
  assign last_bit = (bitcnt_q == (is16 ? 6'd15 : 6'd31));
  assign raw_word = {shreg_q, sd_s};
  assign word     = fit_word(raw_word, is16);

  // ws seen at the previous sample, used for edge detection
  always_ff @(posedge wclk) begin
    if (rst)            ws_prev_q <= 1'b0;
    else if (sample_en) ws_prev_q <= ws_s;
  end

  // Capture FSM state and datapath registers
  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q  <= SYNC;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      chan_q   <= 1'b0;
      stage_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      chan_q   <= chan_d;
      stage_q  <= stage_d;
    end
  end

  // Next-state: word framing, bit shifting, frame assembly and push request
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    chan_d     = chan_q;
    stage_d    = stage_q;
    start      = 1'b0;
    word_done  = 1'b0;
    push       = 1'b0;
    push_frame = '0;
    ferr_set   = 1'b0;

    if (!bus.en) begin
      state_d  = SYNC;
      stage_d  = '0;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (sample_en) begin
      unique case (state_q)
        SYNC: begin
          if (!bus.stereo) begin
            state_d  = SHIFT;
            shreg_d  = '0;
            bitcnt_d = '0;
          end else if (ws_edge && !ws_s) begin
            start = 1'b1;
          end
        end
        ARM: begin
          state_d  = SHIFT;
          shreg_d  = {30'd0, sd_s};
          bitcnt_d = 6'd1;
        end
        SHIFT: begin
          if (last_bit) begin
            // In Philips mode the next ws edge lands on this LSB sample
            word_done = 1'b1;
            state_d   = WAIT;
            if (bus.stereo && ws_edge) start = 1'b1;
          end else if (bus.stereo && ws_edge) begin
            // Word cut short: drop it and only resynchronise on a left word
            ferr_set = 1'b1;
            shreg_d  = '0;
            bitcnt_d = '0;
            if (!ws_s) start = 1'b1;
            else       state_d = SYNC;
          end else begin
            shreg_d  = raw_word[30:0];
            bitcnt_d = bitcnt_q + 6'd1;
          end
        end
        WAIT: begin
          if (!bus.stereo) begin
            state_d  = SHIFT;
            shreg_d  = '0;
            bitcnt_d = '0;
          end else if (ws_edge) begin
            start = 1'b1;
          end
        end
        default: state_d = SYNC;
      endcase

      // New word: left-justified takes the MSB now, Philips one sample later
      if (start) begin
        chan_d = ws_s;
        if (lj) begin
          state_d  = SHIFT;
          shreg_d  = {30'd0, sd_s};
          bitcnt_d = 6'd1;
        end else begin
          state_d  = ARM;
          shreg_d  = '0;
          bitcnt_d = '0;
        end
      end

      if (word_done) begin
        if (!bus.stereo) begin
          push         = 1'b1;
          push_frame.L = word;
          push_frame.R = '0;
        end else if (!chan_q) begin
          stage_d = word;
        end else begin
          push         = 1'b1;
          push_frame.L = stage_q;
          push_frame.R = word;
        end
      end
    end
  end

  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;
  frame_t         mem_q [DEPTH];
  logic           full;
  logic           empty;
  logic           pop;
  logic           wr_ok;
  logic           overrun_q;
  logic           frame_err_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = bus.ren && !empty;
  // A simultaneous pop frees the head slot, which is the slot being written
  assign wr_ok = push && (!full || pop);

  // Frame storage, cleared on reset so the outputs read zero
  always_ff @(posedge wclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_frame;
    end
  end

  // Pointers and sticky error flags; a new error wins over clr_err
  always_ff @(posedge wclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !wr_ok)   overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
      if (ferr_set)         frame_err_q <= 1'b1;
      else if (bus.clr_err) frame_err_q <= 1'b0;
    end
  end

  assign bus.doutL     = mem_q[rd_ptr_q[PTR_W-1:0]].L;
  assign bus.doutR     = mem_q[rd_ptr_q[PTR_W-1:0]].R;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.level     = wr_ptr_q - rd_ptr_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Testbench for i2s_rx_fifo: table of single-frame captures across
// standards/word sizes/slot widths, then overrun, full+pop, frame error
// and mid-frame reset sequences.
module tb_i2s_rx_fifo;
  import i2s_pkg::*;

  localparam int DEPTH = 4;

  logic wclk = 1'b0;
  logic rst;

  always #5 wclk = ~wclk;

  i2s_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  i2s_rx_fifo #(.DEPTH(DEPTH)) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        lj;
    int          slot;
    int          nbits;
    logic [31:0] L;
    logic [31:0] R;
    int          k0;
    logic [31:0] expL;
    logic [31:0] expR;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // One sck period of 8 wclk; mode 1 probes empty around the push,
  // mode 2 raises ren exactly on the push cycle.
  task automatic send_bit(input logic w, input logic d, input int mode);
    bus.ws = w;
    bus.sd = d;
    repeat (4) @(negedge wclk);
    bus.sck = 1'b1;
    repeat (3) @(negedge wclk);
    if (mode == 1) chk("empty_before_push", 32'(bus.empty), 32'd1);
    if (mode == 2) bus.ren = 1'b1;
    @(negedge wclk);
    if (mode == 1) chk("empty_after_push", 32'(bus.empty), 32'd0);
    if (mode == 2) bus.ren = 1'b0;
    bus.sck = 1'b0;
  endtask

  // Frame of 2*S sck with bits k0..k1-1; mode applies to the last right bit.
  task automatic send_frame(input logic lj, input int S, input int N,
                            input logic [31:0] L, input logic [31:0] R,
                            input int k0, input int k1, input int mode);
    logic        ch;
    int          j;
    logic [31:0] wd;
    logic        w;
    logic        d;
    for (int k = k0; k < k1; k++) begin
      ch = (k >= S);
      j  = ch ? k - S : k;
      wd = ch ? R : L;
      if (j < N) d = wd[5'(N - 1 - j)];
      else       d = 1'b0;
      if (lj) w = ch;
      else    w = (k >= S - 1) && (k < 2 * S - 1);
      send_bit(w, d, (k == S + N - 1) ? mode : 0);
    end
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    bus.ren = 1'b0;
    bus.clr_err = 1'b0;
    bus.sck = 1'b0;
    bus.ws = 1'b0;
    bus.sd = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge wclk);
    rst = 1'b0;
    @(negedge wclk);
  endtask

  task automatic cfg(input logic lj, input int nbits);
    bus.standard  = lj ? I2S_LJ : I2S_PHILIPS;
    bus.word_size = (nbits == 16) ? WS_16 : WS_32;
    bus.stereo    = 1'b1;
    @(negedge wclk);
    bus.en = 1'b1;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] eL,
                         input logic [31:0] eR);
    chk({name, "_L"}, bus.doutL, eL);
    chk({name, "_R"}, bus.doutR, eR);
    bus.ren = 1'b1;
    @(negedge wclk);
    bus.ren = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge wclk);
    bus.clr_err = 1'b0;
    @(negedge wclk);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.stereo = 1'b1;
    bus.standard = I2S_PHILIPS;
    bus.word_size = WS_16;
    bus.sck = 1'b0;
    bus.ws = 1'b0;
    bus.sd = 1'b0;
    bus.ren = 1'b0;
    bus.clr_err = 1'b0;

    vecs[0] = '{1'b0, 16, 16, 32'h0000A5C3, 32'h00001234, 0,
                32'h0000A5C3, 32'h00001234};
    vecs[1] = '{1'b1, 32, 32, 32'hDEADBEEF, 32'h0F0F0F0F, 42,
                32'hDEADBEEF, 32'h0F0F0F0F};
`ifdef RX_SIGN_EXT_EN
    vecs[2] = '{1'b1, 16, 16, 32'h00008001, 32'h00007FFF, 0,
                32'hFFFF8001, 32'h00007FFF};
    vecs[4] = '{1'b0, 32, 16, 32'h0000BEEF, 32'h00000001, 0,
                32'hFFFFBEEF, 32'h00000001};
`else
    vecs[2] = '{1'b1, 16, 16, 32'h00008001, 32'h00007FFF, 0,
                32'h00008001, 32'h00007FFF};
    vecs[4] = '{1'b0, 32, 16, 32'h0000BEEF, 32'h00000001, 0,
                32'h0000BEEF, 32'h00000001};
`endif
    vecs[3] = '{1'b0, 32, 32, 32'h12345678, 32'h87654321, 0,
                32'h12345678, 32'h87654321};

    // Reset state
    do_reset();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_doutL", bus.doutL, 32'd0);
    chk("rst_doutR", bus.doutR, 32'd0);

    // Single-frame captures: a sync (or partial) frame, then the data frame
    for (int i = 0; i < 5; i++) begin
      do_reset();
      cfg(vecs[i].lj, vecs[i].nbits);
      send_frame(vecs[i].lj, vecs[i].slot, vecs[i].nbits, vecs[i].L,
                 vecs[i].R, vecs[i].k0, 2 * vecs[i].slot, 0);
      send_frame(vecs[i].lj, vecs[i].slot, vecs[i].nbits, vecs[i].L,
                 vecs[i].R, 0, 2 * vecs[i].slot, (i == 0) ? 1 : 0);
      repeat (2) @(negedge wclk);
      chk($sformatf("v%0d_level", i), 32'(bus.level), 32'd1);
      chk($sformatf("v%0d_frame_err", i), 32'(bus.frame_err), 32'd0);
      pop_chk($sformatf("v%0d", i), vecs[i].expL, vecs[i].expR);
      chk($sformatf("v%0d_empty_after_pop", i), 32'(bus.empty), 32'd1);
    end

    // Overrun: 5 frames into a 4-deep FIFO
    do_reset();
    cfg(1'b0, 16);
    send_frame(1'b0, 16, 16, 32'h0, 32'h0, 0, 32, 0);
    for (int i = 0; i < 4; i++)
      send_frame(1'b0, 16, 16, 32'h1100 + i, 32'h2200 + i, 0, 32, 0);
    chk("ovr_full4", 32'(bus.full), 32'd1);
    chk("ovr_level4", 32'(bus.level), 32'd4);
    chk("ovr_not_yet", 32'(bus.overrun), 32'd0);
    send_frame(1'b0, 16, 16, 32'h1104, 32'h2204, 0, 32, 0);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_level_held", 32'(bus.level), 32'd4);
    for (int i = 0; i < 4; i++)
      pop_chk($sformatf("ovr_pop%0d", i), 32'h1100 + i, 32'h2200 + i);
    chk("ovr_empty", 32'(bus.empty), 32'd1);
    chk("ovr_still_set", 32'(bus.overrun), 32'd1);
    pulse_clr();
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Full FIFO with a pop on the push cycle
    do_reset();
    cfg(1'b0, 16);
    send_frame(1'b0, 16, 16, 32'h0, 32'h0, 0, 32, 0);
    for (int i = 0; i < 4; i++)
      send_frame(1'b0, 16, 16, 32'h1100 + i, 32'h2200 + i, 0, 32, 0);
    send_frame(1'b0, 16, 16, 32'h1104, 32'h2204, 0, 32, 2);
    chk("fr_level", 32'(bus.level), 32'd4);
    chk("fr_full", 32'(bus.full), 32'd1);
    chk("fr_overrun", 32'(bus.overrun), 32'd0);
    for (int i = 1; i < 5; i++)
      pop_chk($sformatf("fr_pop%0d", i), 32'h1100 + i, 32'h2200 + i);
    chk("fr_empty", 32'(bus.empty), 32'd1);

    // ws toggles after 10 bits of a 16-bit left word
    do_reset();
    cfg(1'b0, 16);
    send_frame(1'b0, 16, 16, 32'h0, 32'h0, 0, 32, 0);
    for (int j = 0; j < 10; j++) send_bit(1'b0, 1'b1, 0);
    for (int j = 0; j < 6; j++) send_bit(1'b1, 1'b0, 0);
    chk("ferr_set", 32'(bus.frame_err), 32'd1);
    chk("ferr_no_push", 32'(bus.level), 32'd0);
    pulse_clr();
    chk("ferr_cleared", 32'(bus.frame_err), 32'd0);
    send_frame(1'b0, 16, 16, 32'hFFFF, 32'hFFFF, 0, 32, 0);
    send_frame(1'b0, 16, 16, 32'h5A5A, 32'hC3C3, 0, 32, 0);
    chk("ferr_recover_level", 32'(bus.level), 32'd1);
    pop_chk("ferr_recover", 32'h00005A5A, 32'h0000C3C3);

    // Reset in the middle of a right word
    do_reset();
    cfg(1'b0, 16);
    send_frame(1'b0, 16, 16, 32'h0, 32'h0, 0, 32, 0);
    send_frame(1'b0, 16, 16, 32'h1234, 32'h5678, 0, 32, 0);
    chk("mr_level_before", 32'(bus.level), 32'd1);
    send_frame(1'b0, 16, 16, 32'h7777, 32'h6666, 0, 21, 0);
    rst = 1'b1;
    @(negedge wclk);
    chk("mr_empty", 32'(bus.empty), 32'd1);
    chk("mr_full", 32'(bus.full), 32'd0);
    chk("mr_level", 32'(bus.level), 32'd0);
    chk("mr_doutL", bus.doutL, 32'd0);
    chk("mr_doutR", bus.doutR, 32'd0);
    rst = 1'b0;
    bus.ws = 1'b0;
    @(negedge wclk);
    send_frame(1'b0, 16, 16, 32'h0, 32'h0, 0, 32, 0);
    send_frame(1'b0, 16, 16, 32'h0BCD, 32'h0123, 0, 32, 0);
    chk("mr_after_level", 32'(bus.level), 32'd1);
    pop_chk("mr_after", 32'h00000BCD, 32'h00000123);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2s_rx_fifo.md
Name: i2s_rx_fifo

Overview:
- I2S receive path: captures serial audio (sck, ws, sd) from an external transmitter and deserializes it into 16/32-bit words.
- Assembles left/right pairs and buffers them in a frame FIFO for the parallel consumer.
- Single clock domain: the serial pins are oversampled on the system clock wclk. It is the receive-side counterpart of the transmit FIFO/serializer and uses the same standard/word_size/stereo encodings.

Parameters:
- DEPTH, 4, FIFO capacity in L/R frames; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- wclk  in  1  system clock; must be ≥4× sck frequency.
- rst  in  1  synchronous, active-high reset on wclk.
- en  in  1  receive enable; config inputs change only while en=0.
- stereo  in  1  1=stereo L/R pairs, 0=mono.
- standard  in  2  00=Philips I2S (MSB one sck after ws edge); any other value=left-justified (MSB on ws edge).
- word_size  in  2  00=16-bit, any other value=32-bit.
- sck  in  1  serial bit clock, asynchronous.
- ws  in  1  word select, asynchronous; 0=left, 1=right.
- sd  in  1  serial data, MSB first, asynchronous.
- ren  in  1  pop head frame.
- doutL  out  32  head frame left word (first-word fall-through).
- doutR  out  32  head frame right word.
- full  out  1  FIFO holds DEPTH frames.
- empty  out  1  FIFO holds 0 frames.
- level  out  PTR_W+1  frames stored.
- overrun  out  1  sticky: frame dropped because FIFO full.
- frame_err  out  1  sticky: ws edge arrived before word complete.
- clr_err  in  1  clears both sticky flags (rst also clears them).

Behaviour:
- Reset: pointers=0, empty=1, full=0, level=0, overrun=0, frame_err=0, doutL=doutR=0 (storage cleared), state=SYNC, shift register and bit counter cleared. Reset mid-frame discards the partial frame.
- Input stage: 2-flop synchronizers on sck/ws/sd, then a rising-edge detector. sample_en pulses exactly 1 wclk cycle, 3 wclk cycles after the sck rise. All capture logic advances only on sample_en.
- ws_prev holds ws from the previous sample. A ws edge is ws_s != ws_prev at a sample.
- MSB position: Philips = the sample after the ws edge; left-justified = the same sample as the ws edge.
- FSM states:
  - SYNC: discard data. Stereo: wait for a ws 1→0 edge (left first) → ARM (Philips) or SHIFT (LJ, MSB taken this sample). Mono: first sample after en rises → SHIFT, ws ignored.
  - ARM: next sample → SHIFT, capturing the MSB.
  - SHIFT: shift sd in MSB first and count bits. After N bits (16 or 32) → WAIT. A ws edge before N bits: set frame_err, discard the partial frame, restart the word per the MSB rule (new left word only if ws=0, else → SYNC).
  - WAIT: ignore extra slot bits. A ws edge restarts per the MSB rule. Mono: next sample → SHIFT.
- Word storage: 16-bit words go in [15:0], [31:16]=0.
- Frame assembly: a completed left word goes to the staging register. A completed right word forms {L,R}. Mono: each word forms {word, 32'd0}.
- Push happens on the wclk cycle the last bit is sampled; empty/level update the following cycle.
- Full: push rejected and overrun set, unless ren pops in the same cycle, in which case the push is accepted.
- Pop: ren && !empty advances rd_ptr; doutL/doutR show the next head next cycle. ren while empty is ignored.
- Push+pop same cycle: level unchanged.
- Pointers are PTR_W+1 bits and wrap naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- en=0: FSM forced to SYNC, staging cleared; FIFO contents and read side keep working.

Optional Feature:
- Macro RX_SIGN_EXT_EN.
- Defined: 16-bit words are sign-extended into [31:16] (bit15 replicated).
- Undefined: [31:16]=0.
- 32-bit words are unaffected either way.

Decomposition:
- Package i2s_pkg: standard codes (I2S_PHILIPS=2'b00, I2S_LJ=2'b01), word-size codes (WS_16=2'b00, WS_32=2'b01), rx_state_t enum {SYNC, ARM, SHIFT, WAIT}, frame_t struct {L,R}.
- Sub-module i2s_rx_sync: 3-input synchronizer plus sck rise detector, outputs ws_s, sd_s, sample_en.

Test Plan:
- Philips, stereo, 16-bit, 32-sck frames, L=16'hA5C3, R=16'h1234, wclk=8×sck → one frame; doutL=32'h0000A5C3, doutR=32'h00001234; empty falls 1 cycle after the last right bit is sampled.
- LJ, stereo, 32-bit, 64-sck frames, L=32'hDEADBEEF, R=32'h0F0F0F0F, stream started mid-right-slot → first partial frame discarded, then exact values captured.
- 5 frames with DEPTH=4 and no ren → full=1 after 4, overrun=1, 5th frame dropped; pop 4 → original first 4 frames in order, empty=1; clr_err → overrun=0.
- ws toggled after 10 bits of a 16-bit left word → frame_err=1, no push, next complete frame captured correctly.
- Full FIFO plus ren on the same cycle as a push → push accepted, level stays 4, overrun stays 0.
- rst asserted mid-right-word → all outputs at reset values next cycle; RX_SIGN_EXT_EN build: L=16'h8001 → doutL=32'hFFFF8001.
